nibble_accum_fifo: RTL and testbench
====================================

# nibble_accum_fifo

Parametrised arithmetic unit that extends the team's registered nibble-adder to add, subtract, accumulate and clear modes. It sits between the input pins and the output register stage of the top-level design. Operands arrive with a valid/ready handshake. Results queue in a small output FIFO so that a slow consumer does not drop results.

## Interface

Parameters:
- `W`, 4: operand width in bits (2–8).
- `ACC_W`, 8: accumulator and result width in bits; must be ≥ `W`+1.
- `DEPTH`, 4: result FIFO depth in entries; must be a power of two, ≥ 2.
- `SAT`, 1: 1 = accumulate mode saturates at all-ones; 0 = accumulate mode wraps.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  block can accept a beat.
- `in_a`  in  `W`  operand A.
- `in_b`  in  `W`  operand B.
- `in_mode`  in  2  operation: 00 ADD, 01 SUB, 10 ACC, 11 CLR.
- `out_valid`  out  1  FIFO head holds a result.
- `out_ready`  in  1  consumer takes the head.
- `out_result`  out  `ACC_W`  result at the FIFO head.
- `out_flag`  out  1  carry/borrow/overflow flag at the FIFO head.
- `acc_value`  out  `ACC_W`  current accumulator register, for debug.

## Operation

- Accept: a beat is accepted when `in_valid` & `in_ready` on a rising edge.
- `in_ready` = FIFO not full. It does not depend on `out_ready` in the same cycle: when the FIFO is full, no beat is accepted even if a pop occurs in that cycle.
- Each accepted beat computes one result and flag from `in_a`, `in_b`, `in_mode` and the accumulator value before the edge. The result is pushed into the FIFO on that edge.
- Operands are zero-extended to `ACC_W` bits.

Modes:
- ADD: result = A+B. Flag = bit `W` of the (`W`+1)-bit sum. The accumulator is unchanged.
- SUB: result = (A−B) mod 2^`ACC_W`. Flag = 1 iff A<B. The accumulator is unchanged.
- ACC: sum = acc+A+B, computed at `ACC_W`+1 bits. Flag = sum[`ACC_W`].
  - If flag=1 and `SAT`=1, the result is all-ones; otherwise the result is sum mod 2^`ACC_W`.
  - The accumulator is loaded with the result.
- CLR: the accumulator is cleared to 0. Result = 0, flag = 0. A result is still pushed.

FIFO behaviour:
- Circular buffer of `DEPTH` entries, each `ACC_W`+1 bits. Read and write pointers wrap modulo `DEPTH`. Occupancy is held in a ($clog2(`DEPTH`)+1)-bit counter.
- Pop occurs when `out_valid` & `out_ready`.
- Simultaneous push and pop in the same cycle leaves occupancy unchanged. This is legal whenever the FIFO is non-empty and not full.
- A pop on an empty FIFO is ignored.
- `out_result`/`out_flag` reflect the head entry. Their value is don't-care when `out_valid`=0, but the bench shall compare them only when `out_valid`=1.

Reset:
- When `reset` is 1 at a rising edge: occupancy and pointers go to 0, the accumulator goes to 0, and `out_valid`=0.
- A beat presented in the same cycle as reset is discarded. Reset has priority over push and pop.
- FIFO storage contents are not reset.

## Timing

- Reset values: `in_ready`=1, `out_valid`=0, `acc_value`=0. `out_result`/`out_flag` are don't-care.
- Latency: a beat accepted at edge k appears at the head with `out_valid`=1 after edge k, provided the FIFO was empty. There is no combinational path from `in_*` to `out_*`.
- Throughput: one beat per cycle, sustained while `out_ready`=1.
- `in_ready` falls in the cycle after the `DEPTH`-th unpopped push.
- Back-to-back ACC beats chain correctly: each uses the accumulator value updated by the previous accepted beat.
- `acc_value` updates on the same edge as the accepting beat.

## Test plan

- ADD/SUB basics (W=4): ADD A=0xF, B=0x1 → result 0x10, flag 1. SUB A=3, B=5 → result 0xFE, flag 1. SUB A=5, B=3 → 0x02, flag 0. Each result appears one cycle after acceptance.
- Accumulate with saturation (SAT=1, ACC_W=8): CLR, then 9 ACC beats of A=0xF, B=0xF.
  - Results run 0x1E, 0x3C … 0xF0, then 0xFF with flag 1.
  - `acc_value`=0xFF afterwards.
- Accumulate with wrap (SAT=0), same stimulus: the 9th result is 0x0E with flag 1.
- Backpressure (DEPTH=4): hold `out_ready`=0 and drive 6 ADD beats.
  - Exactly 4 are accepted; `in_ready`=0 from the cycle after the 4th.
  - Release `out_ready`: the 4 results drain in order, then the remaining 2 beats are accepted.
- Full with simultaneous pop: FIFO full, `in_valid`=1, `out_ready`=1.
  - That cycle: no push, one pop.
  - Next cycle: push and pop occur together and occupancy stays at 3.
- Reset mid-operation: 3 results queued and acc=0x2A; assert `reset` for one cycle while `in_valid`=1.
  - Next cycle: `out_valid`=0, `acc_value`=0, `in_ready`=1.
  - The beat presented during reset never appears at the output.

Source files
------------

// File: rtl/nibble_accum_fifo.sv
// Circular result FIFO with an occupancy counter; storage itself is not reset.
// Latency: a pushed entry is visible at rd_dat the cycle after the push edge.
// Backpressure: wr_rdy drops when full, regardless of a same-cycle pop.
module sync_fifo #(
    parameter int DW    = 9,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_vld,
    output logic          wr_rdy,
    input  logic [DW-1:0] wr_dat,
    output logic          rd_vld,
    input  logic          rd_rdy,
    output logic [DW-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign wr_rdy = (count != (AW+1)'(DEPTH));
    assign rd_vld = (count != '0);
    assign push   = wr_vld & wr_rdy;
    assign pop    = rd_vld & rd_rdy;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr] <= wr_dat;
    end
endmodule

// Nibble add/sub/accumulate/clear unit feeding a result FIFO.
// Latency: result at FIFO head one cycle after the accepting edge (FIFO empty).
// Backpressure: in_ready = FIFO not full; independent of out_ready.
module nibble_accum_fifo #(
    parameter int W     = 4,
    parameter int ACC_W = 8,
    parameter int DEPTH = 4,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_result,
    output logic             out_flag,
    output logic [ACC_W-1:0] acc_value
);
    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_CLR = 2'b11
    } mode_e;

    typedef struct packed {
        logic             flag;
        logic [ACC_W-1:0] result;
    } res_t;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [W:0]       add_sum;
    logic [ACC_W:0]   acc_sum;
    res_t             res_d;
    res_t             head;
    logic             accept;

    assign a_ext  = ACC_W'(in_a);
    assign b_ext  = ACC_W'(in_b);
    assign accept = in_valid & in_ready;

    always_comb begin
        add_sum = {1'b0, in_a} + {1'b0, in_b};
        acc_sum = {1'b0, acc_q} + {1'b0, a_ext} + {1'b0, b_ext};
        res_d   = '0;
        case (mode_e'(in_mode))
            MODE_ADD: begin
                res_d.result = ACC_W'(add_sum);
                res_d.flag   = add_sum[W];
            end
            MODE_SUB: begin
                res_d.result = a_ext - b_ext;
                res_d.flag   = (in_a < in_b);
            end
            MODE_ACC: begin
                res_d.flag   = acc_sum[ACC_W];
                // Saturating build clamps on carry-out; wrapping build keeps the low bits.
                res_d.result = (acc_sum[ACC_W] && (SAT != 0)) ? '1 : acc_sum[ACC_W-1:0];
            end
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (accept) begin
            if (mode_e'(in_mode) == MODE_ACC)
                acc_q <= res_d.result;
            else if (mode_e'(in_mode) == MODE_CLR)
                acc_q <= '0;
        end
    end

    sync_fifo #(
        .DW    (ACC_W + 1),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (in_valid),
        .wr_rdy (in_ready),
        .wr_dat (res_d),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (head)
    );

    assign out_result = head.result;
    assign out_flag   = head.flag;
    assign acc_value  = acc_q;
endmodule

// File: tb/tb_nibble_accum_fifo.sv
// Drives a saturating and a wrapping instance with identical stimulus and checks both against a queue model.
module tb_nibble_accum_fifo;
    localparam int W     = 4;
    localparam int ACC_W = 8;
    localparam int DEPTH = 4;
    localparam int MOD   = 1 << ACC_W;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [W-1:0]     in_a = '0;
    logic [W-1:0]     in_b = '0;
    logic [1:0]       in_mode = '0;
    logic             rdy_s, vld_s, flag_s, rdy_w, vld_w, flag_w;
    logic [ACC_W-1:0] res_s, acc_s, res_w, acc_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_accum_fifo #(.W(W), .ACC_W(ACC_W), .DEPTH(DEPTH), .SAT(1)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_s),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(vld_s),
        .out_ready(out_ready), .out_result(res_s), .out_flag(flag_s), .acc_value(acc_s)
    );

    nibble_accum_fifo #(.W(W), .ACC_W(ACC_W), .DEPTH(DEPTH), .SAT(0)) dut_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_w),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(vld_w),
        .out_ready(out_ready), .out_result(res_w), .out_flag(flag_w), .acc_value(acc_w)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int res; int flag; } ent_t;
    ent_t q0[$];
    ent_t q1[$];
    int   macc0 = 0;
    int   macc1 = 0;
    bit   model_on = 1'b0;

    function automatic void compute(input int mode, input int a, input int b, input int acc,
                                    input bit sat, output ent_t e, output int nacc);
        nacc = acc;
        case (mode)
            0: begin e.res = a + b; e.flag = ((a + b) >= (1 << W)) ? 1 : 0; end
            1: begin e.res = (a - b + MOD) % MOD; e.flag = (a < b) ? 1 : 0; end
            2: begin
                e.res  = acc + a + b;
                e.flag = (e.res >= MOD) ? 1 : 0;
                if (e.flag != 0) e.res = sat ? MOD - 1 : e.res - MOD;
                nacc = e.res;
            end
            default: begin e.res = 0; e.flag = 0; nacc = 0; end
        endcase
    endfunction

    always @(posedge clk) begin
        bit   take;
        ent_t e;
        int   n;
        if (reset) begin
            q0.delete();
            q1.delete();
            macc0 = 0;
            macc1 = 0;
        end else begin
            take = in_valid && (q0.size() < DEPTH);
            if (out_ready && q0.size() > 0) void'(q0.pop_front());
            if (out_ready && q1.size() > 0) void'(q1.pop_front());
            if (take) begin
                compute(int'(in_mode), int'(in_a), int'(in_b), macc0, 1'b1, e, n);
                q0.push_back(e);
                macc0 = n;
                compute(int'(in_mode), int'(in_a), int'(in_b), macc1, 1'b0, e, n);
                q1.push_back(e);
                macc1 = n;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("sat.in_ready", int'(rdy_s), (q0.size() < DEPTH) ? 1 : 0);
            check("sat.out_valid", int'(vld_s), (q0.size() > 0) ? 1 : 0);
            check("sat.acc_value", int'(acc_s), macc0);
            if (q0.size() > 0) begin
                check("sat.out_result", int'(res_s), q0[0].res);
                check("sat.out_flag", int'(flag_s), q0[0].flag);
            end
            check("wrap.in_ready", int'(rdy_w), (q1.size() < DEPTH) ? 1 : 0);
            check("wrap.out_valid", int'(vld_w), (q1.size() > 0) ? 1 : 0);
            check("wrap.acc_value", int'(acc_w), macc1);
            if (q1.size() > 0) begin
                check("wrap.out_result", int'(res_w), q1[0].res);
                check("wrap.out_flag", int'(flag_w), q1[0].flag);
            end
        end
    end

    // Records every result the consumer takes from the saturating instance.
    logic [ACC_W:0] log_q[$];
    always @(posedge clk) begin
        if (!reset && vld_s && out_ready) log_q.push_back({flag_s, res_s});
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input int mode, input int a, input int b);
        in_mode  = 2'(mode);
        in_a     = W'(a);
        in_b     = W'(b);
        in_valid = 1'b1;
        check("send.in_ready", int'(rdy_s), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic head_s(input string name, input int r, input int f);
        check({name, ".valid"}, int'(vld_s), 1);
        check({name, ".result"}, int'(res_s), r);
        check({name, ".flag"}, int'(flag_s), f);
    endtask

    task automatic head_w(input string name, input int r, input int f);
        check({name, ".valid"}, int'(vld_w), 1);
        check({name, ".result"}, int'(res_w), r);
        check({name, ".flag"}, int'(flag_w), f);
    endtask

    logic [ACC_W-1:0] sat_tab  [9] = '{8'h1E, 8'h3C, 8'h5A, 8'h78, 8'h96, 8'hB4, 8'hD2, 8'hF0, 8'hFF};
    logic [ACC_W-1:0] wrap_tab [9] = '{8'h1E, 8'h3C, 8'h5A, 8'h78, 8'h96, 8'hB4, 8'hD2, 8'hF0, 8'h0E};

    initial begin
        int  idx;
        bit  rdy;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        model_on = 1'b1;
        check("rst.in_ready", int'(rdy_s), 1);
        check("rst.out_valid", int'(vld_s), 0);
        check("rst.acc_value", int'(acc_s), 0);

        out_ready = 1'b1;
        send(0, 15, 1);  head_s("add_f_1", 'h10, 1);
        send(1, 3, 5);   head_s("sub_3_5", 'hFE, 1);
        send(1, 5, 3);   head_s("sub_5_3", 'h02, 0);

        send(3, 0, 0);   head_s("clr", 0, 0);
        for (int k = 0; k < 9; k++) begin
            send(2, 15, 15);
            head_s("acc_sat", int'(sat_tab[k]), (k == 8) ? 1 : 0);
            head_w("acc_wrap", int'(wrap_tab[k]), (k == 8) ? 1 : 0);
        end
        check("acc_sat.final", int'(acc_s), 'hFF);
        check("acc_wrap.final", int'(acc_w), 'h0E);

        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        log_q.delete();
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_mode  = 2'd0;
            in_a     = W'(idx + 1);
            in_b     = W'(idx);
            in_valid = 1'b1;
            rdy      = rdy_s;
            @(posedge clk);
            #1;
            if (rdy) idx++;
        end
        check("bp.accepted", idx, 4);
        check("bp.in_ready", int'(rdy_s), 0);
        head_s("bp.head", 1, 0);

        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 6; c++) begin
            in_mode  = 2'd0;
            in_a     = W'(idx + 1);
            in_b     = W'(idx);
            in_valid = 1'b1;
            rdy      = rdy_s;
            @(posedge clk);
            #1;
            if (rdy) idx++;
            if (c == 0) begin
                check("fullpop.no_push", idx, 4);
                check("fullpop.in_ready", int'(rdy_s), 1);
            end
            if (c == 1) begin
                check("pushpop.accepted", idx, 5);
                check("pushpop.in_ready", int'(rdy_s), 1);
            end
        end
        check("bp.all_accepted", idx, 6);
        in_valid = 1'b0;
        for (int c = 0; c < 20 && vld_s; c++) begin
            @(posedge clk);
            #1;
        end
        check("drain.empty", int'(vld_s), 0);
        check("drain.count", log_q.size(), 6);
        for (int i = 0; i < 6 && i < log_q.size(); i++)
            check("drain.order", int'(log_q[i]), 2 * i + 1);

        out_ready = 1'b0;
        send(3, 0, 0);
        send(2, 15, 15);
        send(2, 6, 6);
        check("pre_rst.acc", int'(acc_s), 'h2A);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_mode  = 2'd0;
        in_a     = W'(7);
        in_b     = W'(7);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        log_q.delete();
        check("post_rst.out_valid", int'(vld_s), 0);
        check("post_rst.acc", int'(acc_s), 0);
        check("post_rst.in_ready", int'(rdy_s), 1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst.no_ghost", log_q.size(), 0);
        send(0, 2, 3);   head_s("post_rst.add", 5, 0);
        repeat (2) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end
endmodule
